memory_game_sm: RTL and testbench
=================================

// Module: memory_game_sm
// PURPOSE
//  Game sequencer for the 4x4 memory-tile game. Owns the hidden pattern (A0..A3), the guess map
//  (B0..B3), the cursor (X row, Y column) and the one-hot phase flags Qi/Qfo/Qp/Qg/Ql that the
//  VGA block controller consumes. Sits between debounced button pulses and the display path.
// PARAMETERS
//  SHOW_TICKS    3        tick pulses the pattern stays visible in Qfo (>=1)
//  RESULT_TICKS  2        tick pulses spent in Qg before returning to Qi (>=1)
//  TIMER_W       8        phase timer width; SHOW_TICKS, RESULT_TICKS < 2**TIMER_W
//  LFSR_SEED     16'hACE1 LFSR reset value (must be nonzero)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  tick       in   1   one-cycle slow enable that paces phase timers
//  start      in   1   one-cycle pulse: begin round / acknowledge loss
//  up,down    in   1   one-cycle pulses: cursor row -1 / +1
//  left,right in   1   one-cycle pulses: cursor column -1 / +1
//  sel        in   1   one-cycle pulse: guess tile under cursor
//  X          out  2   cursor row (0 = top)
//  Y          out  2   cursor column (0 = left); tile index k = 4*X+Y, bit Y of row word X
//  A0..A3     out  4   pattern rows; 1 = tile is part of pattern
//  B0..B3     out  4   guess rows; 1 = tile has been guessed
//  Qi,Qfo,Qp,Qg,Ql out 1 each  one-hot phase: idle, flash-on, play, good, lost
//  level      out  4   rounds won since last loss, saturates at 15
// BEHAVIOUR
//  Reset: state Qi; X=Y=0; A=B=0; level=0; timer=0; LFSR=LFSR_SEED. Outputs are registered.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk cycle in every state.
//  Qi:  on start -> capture pattern P = lfsr & lfsr_next_draw (the two consecutive values);
//       if P==0 use lfsr alone. Load A rows from P[3:0],P[7:4],P[11:8],P[15:12]; clear B;
//       timer=0; -> Qfo next cycle. Other inputs ignored.
//  Qfo: pattern shown. Timer increments on tick; on the tick that makes timer==SHOW_TICKS
//       -> Qp, timer=0, X=Y=0. Buttons ignored.
//  Qp:  per cycle at most one action, priority sel > up > down > left > right.
//       Cursor wraps modulo 4 (up at X=0 -> X=3, right at Y=3 -> Y=0).
//       sel on tile with B=1: no change. sel on tile with B=0: set B bit next cycle; then
//       if A bit=0 -> Ql same edge; else if (B|new bit)==A -> Qg same edge, timer=0.
//       start ignored.
//  Qg:  level = min(level+1,15) on entry. Timer counts ticks; at RESULT_TICKS -> Qi,
//       A and B retained until next start.
//  Ql:  level=0 on entry; A,B held so display shows the miss. start -> Qi.
//  Exactly one Q flag high at all times after reset; tick is ignored outside Qfo/Qg.
//  Simultaneous tick+button in Qfo/Qg: tick processed, button dropped.
//  rst mid-round: immediate return to reset values, no pending guess survives.
//  Latency: button pulse -> visible output change = 1 clk.
// STRUCTURE
//  Package memory_game_pkg: state enum (S_IDLE,S_FLASH,S_PLAY,S_GOOD,S_LOST), 4x4 grid
//   constants (GRID_N=4), LFSR tap mask, helper function tile_idx(x,y).
//  Sub-module lfsr16 (clk, rst, seed param, q[15:0], q_next[15:0]); rest is one FSM + datapath.
// TESTING
//  Reset with rst=1 mid-Qp -> Qi=1, A=B=0, X=Y=0, level=0 within same cycle (async).
//  start in Qi; SHOW_TICKS=3: Qfo for exactly 3 tick pulses, then Qp, X=Y=0; A!=0.
//  In Qp force A0=4'b0001 only: sel at (0,0) -> B0=4'b0001, Qg=1, level=1; 2 ticks -> Qi.
//  Qp, cursor at (0,0): up -> X=3; left -> Y=3; up+sel same cycle -> only guess taken.
//  sel on tile with A=0 -> B bit set, Ql=1, level=0; second sel ignored; start -> Qi.
//  sel twice on same correct tile -> B unchanged, state stays Qp; 16 wins -> level=15.

Source files
------------

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory-tile game sequencer.
// The state encoding is one-hot so the phase flags come straight off the state register.
package memory_game_pkg;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FLASH = 5'b00010,
        S_PLAY  = 5'b00100,
        S_GOOD  = 5'b01000,
        S_LOST  = 5'b10000
    } state_t;

    localparam int          GRID_N    = 4;
    // Fibonacci feedback taps 16,14,13,11 expressed on a right-shifting register (bits 0,2,3,5)
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [3:0]  LEVEL_MAX = 4'd15;

    function automatic logic [3:0] tile_idx(input logic [1:0] x, input logic [1:0] y);
        return 4'(int'(x) * GRID_N + int'(y));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; q_next exposes the following value so a caller
// can combine two consecutive draws in a single cycle.
module lfsr16
    import memory_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q,
    output logic [15:0] q_next
);

    assign q_next = {^(q & LFSR_TAPS), q[15:1]};

    // Shift register, advances every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/memory_game_sm.sv
// Game sequencer for the 4x4 memory-tile game: pattern draw, flash, cursor play,
// win/loss bookkeeping and the one-hot phase flags consumed by the display path.
module memory_game_sm
    import memory_game_pkg::*;
#(
    parameter int          SHOW_TICKS   = 3,
    parameter int          RESULT_TICKS = 2,
    parameter int          TIMER_W      = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       sel,
    output logic [1:0] X,
    output logic [1:0] Y,
    output logic [3:0] A0,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic [3:0] B0,
    output logic [3:0] B1,
    output logic [3:0] B2,
    output logic [3:0] B3,
    output logic       Qi,
    output logic       Qfo,
    output logic       Qp,
    output logic       Qg,
    output logic       Ql,
    output logic [3:0] level
);

    localparam logic [TIMER_W-1:0] SHOW_LIM   = TIMER_W'(SHOW_TICKS);
    localparam logic [TIMER_W-1:0] RESULT_LIM = TIMER_W'(RESULT_TICKS);

    state_t               state_r, state_s;
    logic [1:0]           x_r, x_s, y_r, y_s;
    logic [15:0]          a_r, a_s, b_r, b_s;
    logic [3:0]           level_r, level_s;
    logic [TIMER_W-1:0]   timer_r, timer_s;
    logic [15:0]          lfsr_q_s, lfsr_next_s, draw_s, pattern_s, guess_s;
    logic [3:0]           k_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .q      (lfsr_q_s),
        .q_next (lfsr_next_s)
    );

    // Next-state and datapath decisions for all game registers
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        y_s       = y_r;
        a_s       = a_r;
        b_s       = b_r;
        level_s   = level_r;
        timer_s   = timer_r;
        k_s       = tile_idx(x_r, y_r);
        draw_s    = lfsr_q_s & lfsr_next_s;
        pattern_s = (draw_s == 16'd0) ? lfsr_q_s : draw_s;
        guess_s   = b_r | (16'd1 << k_s);

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    a_s     = pattern_s;
                    b_s     = 16'd0;
                    timer_s = '0;
                    state_s = S_FLASH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FLASH: begin
                if (tick) begin
                    timer_s = timer_r + 1'b1;
                    if (timer_s == SHOW_LIM) begin
                        state_s = S_PLAY;
                        timer_s = '0;
                        x_s     = 2'd0;
                        y_s     = 2'd0;
                    end else begin
                        state_s = S_FLASH;
                    end
                end else begin
                    state_s = S_FLASH;
                end
            end
            S_PLAY: begin
                if (sel) begin
                    // A repeat guess on an already-revealed tile consumes the press silently
                    if (!b_r[k_s]) begin
                        b_s = guess_s;
                        if (!a_r[k_s]) begin
                            state_s = S_LOST;
                            level_s = 4'd0;
                        end else if (guess_s == a_r) begin
                            state_s = S_GOOD;
                            timer_s = '0;
                            level_s = (level_r == LEVEL_MAX) ? LEVEL_MAX : level_r + 4'd1;
                        end else begin
                            state_s = S_PLAY;
                        end
                    end else begin
                        state_s = S_PLAY;
                    end
                end else if (up) begin
                    x_s = x_r - 2'd1;
                end else if (down) begin
                    x_s = x_r + 2'd1;
                end else if (left) begin
                    y_s = y_r - 2'd1;
                end else if (right) begin
                    y_s = y_r + 2'd1;
                end else begin
                    state_s = S_PLAY;
                end
            end
            S_GOOD: begin
                if (tick) begin
                    timer_s = timer_r + 1'b1;
                    if (timer_s == RESULT_LIM) begin
                        state_s = S_IDLE;
                        timer_s = '0;
                    end else begin
                        state_s = S_GOOD;
                    end
                end else begin
                    state_s = S_GOOD;
                end
            end
            S_LOST: begin
                if (start) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_LOST;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Game registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            x_r     <= 2'd0;
            y_r     <= 2'd0;
            a_r     <= 16'd0;
            b_r     <= 16'd0;
            level_r <= 4'd0;
            timer_r <= '0;
        end else begin
            state_r <= state_s;
            x_r     <= x_s;
            y_r     <= y_s;
            a_r     <= a_s;
            b_r     <= b_s;
            level_r <= level_s;
            timer_r <= timer_s;
        end
    end

    assign X     = x_r;
    assign Y     = y_r;
    assign A0    = a_r[3:0];
    assign A1    = a_r[7:4];
    assign A2    = a_r[11:8];
    assign A3    = a_r[15:12];
    assign B0    = b_r[3:0];
    assign B1    = b_r[7:4];
    assign B2    = b_r[11:8];
    assign B3    = b_r[15:12];
    assign Qi    = state_r[0];
    assign Qfo   = state_r[1];
    assign Qp    = state_r[2];
    assign Qg    = state_r[3];
    assign Ql    = state_r[4];
    assign level = level_r;

endmodule

// File: tb/tb_memory_game_sm.sv
// Self-checking bench for memory_game_sm: cursor vector table, scripted rounds and
// random stimulus, all compared against a game-rule reference model.
module tb_memory_game_sm;

    localparam int SHOW   = 3;
    localparam int RESULT = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    // button vector layout {tick,start,up,down,left,right,sel}
    localparam logic [6:0] B_NONE  = 7'b0000000;
    localparam logic [6:0] B_TICK  = 7'b1000000;
    localparam logic [6:0] B_START = 7'b0100000;
    localparam logic [6:0] B_UP    = 7'b0010000;
    localparam logic [6:0] B_DOWN  = 7'b0001000;
    localparam logic [6:0] B_LEFT  = 7'b0000100;
    localparam logic [6:0] B_RIGHT = 7'b0000010;
    localparam logic [6:0] B_SEL   = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, start = 1'b0, up = 1'b0, down = 1'b0;
    logic left = 1'b0, right = 1'b0, sel = 1'b0;
    logic [1:0] X, Y;
    logic [3:0] A0, A1, A2, A3, B0, B1, B2, B3, level;
    logic Qi, Qfo, Qp, Qg, Ql;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 flash, 2 play, 3 good, 4 lost
    int          m_phase, m_x, m_y, m_lvl, m_tmr;
    logic [15:0] m_lfsr, m_pat, m_gss;

    typedef struct {
        logic [6:0] btn;
        logic [1:0] ex;
        logic [1:0] ey;
    } vec_t;
    vec_t tbl[13];

    memory_game_sm dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .up(up), .down(down),
        .left(left), .right(right), .sel(sel), .X(X), .Y(Y),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .B0(B0), .B1(B1), .B2(B2), .B3(B3),
        .Qi(Qi), .Qfo(Qfo), .Qp(Qp), .Qg(Qg), .Ql(Ql), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_x = 0; m_y = 0; m_lvl = 0; m_tmr = 0;
        m_pat = 16'd0; m_gss = 16'd0; m_lfsr = SEED;
    endtask

    task automatic model_step(input logic [6:0] b);
        logic [15:0] cur, p;
        int k;
        cur = m_lfsr;
        k = m_x * 4 + m_y;
        case (m_phase)
            0: if (b[5]) begin
                p = cur & lfsr_step(cur);
                if (p == 16'd0) p = cur;
                m_pat = p; m_gss = 16'd0; m_tmr = 0; m_phase = 1;
            end
            1: if (b[6]) begin
                m_tmr++;
                if (m_tmr == SHOW) begin m_phase = 2; m_tmr = 0; m_x = 0; m_y = 0; end
            end
            2: begin
                if (b[0]) begin
                    if (!m_gss[k]) begin
                        m_gss[k] = 1'b1;
                        if (!m_pat[k]) begin
                            m_phase = 4; m_lvl = 0;
                        end else if (m_gss == m_pat) begin
                            m_phase = 3; m_tmr = 0; m_lvl = (m_lvl < 15) ? m_lvl + 1 : 15;
                        end
                    end
                end else if (b[4]) m_x = (m_x + 3) % 4;
                else if (b[3]) m_x = (m_x + 1) % 4;
                else if (b[2]) m_y = (m_y + 3) % 4;
                else if (b[1]) m_y = (m_y + 1) % 4;
            end
            3: if (b[6]) begin
                m_tmr++;
                if (m_tmr == RESULT) begin m_phase = 0; m_tmr = 0; end
            end
            4: if (b[5]) m_phase = 0;
            default: ;
        endcase
        m_lfsr = lfsr_step(cur);
    endtask

    task automatic compare_all();
        check("X", X, m_x);
        check("Y", Y, m_y);
        check("A", {A3, A2, A1, A0}, m_pat);
        check("B", {B3, B2, B1, B0}, m_gss);
        check("Q", {Ql, Qg, Qp, Qfo, Qi}, 32'd1 << m_phase);
        check("level", level, m_lvl);
    endtask

    task automatic cycle(input logic [6:0] b);
        @(negedge clk);
        {tick, start, up, down, left, right, sel} = b;
        @(posedge clk);
        #1;
        {tick, start, up, down, left, right, sel} = B_NONE;
        model_step(b);
        compare_all();
    endtask

    // Asynchronous reset asserted between edges, outputs checked before any clock
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_Qi", Qi, 1);
        check("rst_level", level, 0);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_round();
        cycle(B_START);
        check("start_Qfo", Qfo, 1);
        for (int t = 0; t < SHOW; t++) begin
            cycle(B_NONE);
            cycle(B_TICK | B_UP);
            if (t < SHOW - 1) check("flash_hold", Qfo, 1);
        end
        check("flash_Qp", Qp, 1);
        check("flash_XY", {X, Y}, 0);
        check("A_nonzero", ({A3, A2, A1, A0} != 16'd0), 1);
    endtask

    task automatic goto_tile(input int tx, input int ty);
        while (m_x != tx) cycle(B_DOWN);
        while (m_y != ty) cycle(B_RIGHT);
    endtask

    task automatic win_round();
        for (int k = 0; k < 16; k++) begin
            if (m_pat[k] && !m_gss[k]) begin
                goto_tile(k / 4, k % 4);
                cycle(B_SEL);
            end
        end
        check("win_Qg", Qg, 1);
    endtask

    task automatic finish_result();
        for (int t = 0; t < RESULT; t++) cycle(B_TICK);
        check("result_Qi", Qi, 1);
    endtask

    initial begin
        int kk;
        logic [15:0] saved_b;

        tbl[0]  = '{B_UP,             2'd3, 2'd0};
        tbl[1]  = '{B_UP,             2'd2, 2'd0};
        tbl[2]  = '{B_DOWN,           2'd3, 2'd0};
        tbl[3]  = '{B_DOWN,           2'd0, 2'd0};
        tbl[4]  = '{B_LEFT,           2'd0, 2'd3};
        tbl[5]  = '{B_RIGHT,          2'd0, 2'd0};
        tbl[6]  = '{B_RIGHT,          2'd0, 2'd1};
        tbl[7]  = '{B_UP | B_DOWN,    2'd3, 2'd1};
        tbl[8]  = '{B_DOWN | B_LEFT,  2'd0, 2'd1};
        tbl[9]  = '{B_LEFT | B_RIGHT, 2'd0, 2'd0};
        tbl[10] = '{B_START,          2'd0, 2'd0};
        tbl[11] = '{B_TICK,           2'd0, 2'd0};
        tbl[12] = '{B_DOWN | B_RIGHT, 2'd1, 2'd0};

        do_reset();
        start_round();

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].btn);
            check("tbl_X", X, tbl[i].ex);
            check("tbl_Y", Y, tbl[i].ey);
            check("tbl_Qp", Qp, 1);
        end

        // up+sel in the same cycle: only the guess is taken
        kk = 0;
        while (!m_pat[kk]) kk++;
        goto_tile(kk / 4, kk % 4);
        cycle(B_UP | B_SEL);
        check("upsel_X", X, kk / 4);
        check("upsel_B", {B3, B2, B1, B0} >> kk, 1);
        if (m_phase == 2) begin
            saved_b = {B3, B2, B1, B0};
            cycle(B_SEL);
            check("resel_B", {B3, B2, B1, B0}, saved_b);
            check("resel_Qp", Qp, 1);
        end
        win_round();
        check("level_1", level, 1);
        finish_result();

        // miss on a tile outside the pattern
        start_round();
        kk = 0;
        while (kk < 15 && m_pat[kk]) kk++;
        if (!m_pat[kk]) begin
            goto_tile(kk / 4, kk % 4);
            cycle(B_SEL);
            check("miss_Ql", Ql, 1);
            check("miss_level", level, 0);
            saved_b = {B3, B2, B1, B0};
            cycle(B_SEL);
            check("miss_sel_ignored", {B3, B2, B1, B0}, saved_b);
            cycle(B_START);
            check("lost_to_Qi", Qi, 1);
        end else begin
            win_round();
            finish_result();
        end

        // level saturation across 16 consecutive wins
        do_reset();
        for (int r = 0; r < 16; r++) begin
            start_round();
            win_round();
            finish_result();
        end
        check("level_sat", level, 15);

        // reset in the middle of play
        start_round();
        cycle(B_DOWN);
        do_reset();
        check("rst_XY", {X, Y}, 0);
        check("rst_AB", {A3, A2, A1, A0, B3, B2, B1, B0}, 0);

        for (int n = 0; n < 3000; n++) begin
            cycle(7'($urandom) & 7'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
